pc_step_sequencer: RTL and testbench
====================================

# pc_step_sequencer

Hardware control sequencer for the single-cycle datapath `PC`: it drives the datapath's instruction address and write-enable controls from a built-in step program. It also captures the datapath's register-file and data-memory probe values at the end of every step. It sits beside `PC` at top level and replaces hand-driven stimulus, so a program run can be launched on silicon with one `start` pulse.

## Interface
- `NUM_STEPS`, default 5: number of program steps executed per run (1..2^ADDR_W).
- `ADDR_W`, default 3: width of `instruction_A`.
- `HOLD_CYCLES`, default 10: clock cycles per step; minimum 3.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  launch a run; sampled only in IDLE.
- `instruction_A`  out  ADDR_W  instruction address to `PC`.
- `RegWrite`  out  1  register-file write enable to `PC`.
- `MemWrite`  out  1  data-memory write enable to `PC`.
- `probe_reg`  in  32  register-file probe from `PC`.
- `probe_mem`  in  32  data-memory probe from `PC`.
- `busy`  out  1  high from SETUP of step 0 through SAMPLE of the last step.
- `done`  out  1  high in DONE state.
- `cap_valid`  out  1  one-cycle pulse per captured step.
- `cap_idx`  out  ADDR_W  step index of the current capture.
- `cap_reg`, `cap_mem`  out  32 each  captured probe values.
- `signature`  out  32  running capture checksum; see Configuration.

## Operation
- Step control ROM, giving {RegWrite, MemWrite} per step:
  - step 0: 00.
  - step 1: 10.
  - step 2: 01.
  - step 3: 10.
  - step 4: 10.
  - steps ≥5: 00.
- RegWrite and MemWrite are never both high.
- FSM states: IDLE, SETUP, EXEC, SAMPLE, DONE.
  - IDLE: `start`=1 moves to SETUP with step=0.
  - SETUP (1 cycle): `instruction_A`=step; both write enables low.
  - EXEC (HOLD_CYCLES-2 cycles): write enables take the ROM value; `instruction_A` is held.
  - SAMPLE (1 cycle): write enables are low.
    - On exit, register `probe_reg`/`probe_mem` into `cap_reg`/`cap_mem` and `cap_idx`=step.
    - `cap_valid` pulses the following cycle.
    - Then go to SETUP with step+1, or to DONE if step=NUM_STEPS-1.
  - DONE: `done`=1; `start`=1 returns to SETUP, step=0, and clears `done`. Otherwise DONE holds.
- `start` is ignored in SETUP, EXEC and SAMPLE.
- Write enables drop one full cycle before every address change, so no write ever sees a changing address.
- The step counter is ADDR_W+1 bits internally. `instruction_A` is its low ADDR_W bits, so there is no wrap when NUM_STEPS = 2^ADDR_W.
- Reset values:
  - FSM = IDLE.
  - `instruction_A`=0.
  - RegWrite=MemWrite=0.
  - busy=done=cap_valid=0.
  - cap_idx=0; cap_reg=cap_mem=0; signature=0.
- Reset asserted mid-run forces all of these values on the next edge and discards the step in progress.

## Timing
- All outputs are registered.
- With `start` sampled high at edge t:
  - SETUP of step k occupies cycle t+1+k·HOLD_CYCLES.
  - EXEC occupies the next HOLD_CYCLES-2 cycles.
  - SAMPLE occupies the cycle after EXEC.
- `cap_valid` for step k is high in cycle t+1+(k+1)·HOLD_CYCLES, the same cycle as SETUP of step k+1 or the first DONE cycle.
- `done` rises at edge t+1+NUM_STEPS·HOLD_CYCLES. With defaults this is 51 cycles after the `start` edge.
- Probes are sampled HOLD_CYCLES-1 cycles after the address is applied. `PC` has single-cycle latency, so the sampled values are stable.
- `start` and `reset` in the same cycle: reset wins.

## Configuration
- `PC_SEQ_SIGNATURE_EN` defined:
  - `signature` is updated on every `cap_valid` as signature = {signature[30:0], signature[31]} ^ cap_reg ^ cap_mem.
  - It is cleared by reset and at the start of each run.
- `PC_SEQ_SIGNATURE_EN` undefined:
  - `signature` is tied to 0.
  - No accumulator logic is built.

## Test plan
- Reset held 3 cycles, then released with `start`=0 -> all outputs 0, FSM stays IDLE for 20 cycles.
- `start` pulse with defaults, run to completion:
  - `instruction_A` steps 0→4, each held 10 cycles.
  - RegWrite high 8 cycles in each of steps 1, 3 and 4; MemWrite high 8 cycles in step 2.
  - Exactly 5 `cap_valid` pulses, with `cap_idx` 0..4.
  - `done` rises 51 cycles after the `start` edge.
- Probe model returning probe_reg=0x1000_0000+step and probe_mem=0xA000_0000+step -> `cap_reg`/`cap_mem` match the model values for each `cap_idx`.
- `start` re-pulsed during step 2 -> ignored: the step sequence and `done` timing are unchanged.
- `reset` asserted in EXEC of step 3 -> next cycle: `instruction_A`=0, RegWrite=0, busy=0; a following `start` restarts cleanly from step 0.
- With `PC_SEQ_SIGNATURE_EN` defined and a constant probe of 0x0000_0001 on both inputs -> `signature`=0 after the run, because each step XORs identical values. With probe_reg=1 and probe_mem=0 -> final `signature`=0x0000_001F.

Source files
------------

// File: rtl/pc_step_sequencer_if.sv
// Sequencer <-> PC datapath bundle: address/write-enable controls, probes, capture results.
// master = sequencer side, slave = datapath/launcher side.
interface pc_step_sequencer_if #(
    parameter int ADDR_W = 3
);
    logic              start;
    logic [ADDR_W-1:0] instruction_A;
    logic              RegWrite;
    logic              MemWrite;
    logic [31:0]       probe_reg;
    logic [31:0]       probe_mem;
    logic              busy;
    logic              done;
    logic              cap_valid;
    logic [ADDR_W-1:0] cap_idx;
    logic [31:0]       cap_reg;
    logic [31:0]       cap_mem;
    logic [31:0]       signature;

    modport master (
        input  start, probe_reg, probe_mem,
        output instruction_A, RegWrite, MemWrite, busy, done,
               cap_valid, cap_idx, cap_reg, cap_mem, signature
    );

    modport slave (
        output start, probe_reg, probe_mem,
        input  instruction_A, RegWrite, MemWrite, busy, done,
               cap_valid, cap_idx, cap_reg, cap_mem, signature
    );
endinterface

// File: rtl/pc_step_sequencer.sv
// Step-program sequencer driving PC address/write enables and capturing its probes.
// Optional running capture checksum enabled by defining PC_SEQ_SIGNATURE_EN.
module pc_step_sequencer #(
    parameter int NUM_STEPS   = 5,
    parameter int ADDR_W      = 3,
    parameter int HOLD_CYCLES = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    pc_step_sequencer_if.master   bus
);
    localparam int CNT_W = ADDR_W + 1;
    localparam int HW    = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_EXEC, S_SAMPLE, S_DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  step;
    logic [HW-1:0]     hold;
    logic              start_q;
    logic [ADDR_W-1:0] addr_q;
    logic              reg_we, mem_we;
    logic              busy_q, done_q, cap_valid_q;
    logic [ADDR_W-1:0] cap_idx_q;
    logic [31:0]       cap_reg_q, cap_mem_q;

    // {RegWrite, MemWrite}; at most one bit set per step
    function automatic logic [1:0] step_we(input logic [CNT_W-1:0] s);
        case (s)
            CNT_W'(1), CNT_W'(3), CNT_W'(4): step_we = 2'b10;
            CNT_W'(2):                       step_we = 2'b01;
            default:                         step_we = 2'b00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            step        <= '0;
            hold        <= '0;
            start_q     <= 1'b0;
            addr_q      <= '0;
            reg_we      <= 1'b0;
            mem_we      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cap_valid_q <= 1'b0;
            cap_idx_q   <= '0;
            cap_reg_q   <= '0;
            cap_mem_q   <= '0;
        end else begin
            // start only registers while launchable, so pulses mid-run never leak into DONE
            start_q     <= bus.start && (state == S_IDLE || state == S_DONE);
            cap_valid_q <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_q) begin
                        state  <= S_SETUP;
                        step   <= '0;
                        addr_q <= '0;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                    end
                end
                S_SETUP: begin
                    state            <= S_EXEC;
                    hold             <= '0;
                    {reg_we, mem_we} <= step_we(step);
                end
                S_EXEC: begin
                    if (hold == HW'(HOLD_CYCLES - 3)) begin
                        state  <= S_SAMPLE;
                        reg_we <= 1'b0;
                        mem_we <= 1'b0;
                    end else begin
                        hold <= hold + HW'(1);
                    end
                end
                S_SAMPLE: begin
                    cap_reg_q   <= bus.probe_reg;
                    cap_mem_q   <= bus.probe_mem;
                    cap_idx_q   <= step[ADDR_W-1:0];
                    cap_valid_q <= 1'b1;
                    if (step == CNT_W'(NUM_STEPS - 1)) begin
                        state  <= S_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        state  <= S_SETUP;
                        step   <= step + CNT_W'(1);
                        addr_q <= ADDR_W'(step + CNT_W'(1));
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.instruction_A = addr_q;
    assign bus.RegWrite      = reg_we;
    assign bus.MemWrite      = mem_we;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.cap_valid     = cap_valid_q;
    assign bus.cap_idx       = cap_idx_q;
    assign bus.cap_reg       = cap_reg_q;
    assign bus.cap_mem       = cap_mem_q;

`ifdef PC_SEQ_SIGNATURE_EN
    logic [31:0] sig_q;

    always_ff @(posedge clk) begin
        if (reset)
            sig_q <= '0;
        else if ((state == S_IDLE || state == S_DONE) && start_q)
            sig_q <= '0;
        else if (cap_valid_q)
            sig_q <= {sig_q[30:0], sig_q[31]} ^ cap_reg_q ^ cap_mem_q;
    end

    assign bus.signature = sig_q;
`else
    assign bus.signature = '0;
`endif
endmodule

// File: tb/tb_pc_step_sequencer.sv
// Self-checking bench for pc_step_sequencer: cycle-indexed reference model plus directed runs
// with randomized probe values and start noise.
module tb_pc_step_sequencer;
    localparam int NS = 5;
    localparam int AW = 3;
    localparam int H  = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_step_sequencer_if #(.ADDR_W(AW)) bus();

    pc_step_sequencer #(.NUM_STEPS(NS), .ADDR_W(AW), .HOLD_CYCLES(H)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // PC probe stand-in: value depends on the currently applied address
    logic [31:0] reg_base, mem_base;
    logic        inc_en;
    assign bus.probe_reg = reg_base + (inc_en ? 32'(bus.instruction_A) : 32'd0);
    assign bus.probe_mem = mem_base + (inc_en ? 32'(bus.instruction_A) : 32'd0);

    int compared   = 0;
    int mismatched = 0;

    // Model: r = cycles since step 0 SETUP began (-1 when not running)
    int          r = -1;
    bit          pend = 0, done_m = 0, cv_m = 0;
    int          addr_m = 0, idx_m = 0;
    logic [31:0] creg_m = 0, cmem_m = 0, sig_m = 0;

    function automatic logic [1:0] rom_m(input int k);
        if (k == 1 || k == 3 || k == 4) return 2'b10;
        if (k == 2) return 2'b01;
        return 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        int k;
        if (reset) begin
            r = -1; pend = 0; done_m = 0; cv_m = 0;
            addr_m = 0; idx_m = 0; creg_m = 0; cmem_m = 0; sig_m = 0;
        end else begin
`ifdef PC_SEQ_SIGNATURE_EN
            if (cv_m) sig_m = {sig_m[30:0], sig_m[31]} ^ creg_m ^ cmem_m;
`endif
            cv_m = 0;
            if (r >= 0) begin
                r++;
                if (r % H == 0) begin
                    k      = r / H - 1;
                    idx_m  = k;
                    creg_m = reg_base + (inc_en ? 32'(k) : 32'd0);
                    cmem_m = mem_base + (inc_en ? 32'(k) : 32'd0);
                    cv_m   = 1;
                    if (r == NS * H) begin
                        r = -1;
                        done_m = 1;
                    end
                end
            end else if (pend) begin
                pend = 0; r = 0; done_m = 0; sig_m = 0;
            end else if (bus.start) begin
                pend = 1;
            end
        end
    endtask

    task automatic check_all();
        int p;
        logic [1:0] we;
        we = 2'b00;
        if (r >= 0) begin
            addr_m = r / H;
            p = r % H;
            if (p >= 1 && p <= H - 2) we = rom_m(r / H);
        end
        chk("instruction_A", 32'(bus.instruction_A), 32'(addr_m));
        chk("RegWrite", 32'(bus.RegWrite), 32'(we[1]));
        chk("MemWrite", 32'(bus.MemWrite), 32'(we[0]));
        chk("busy", 32'(bus.busy), 32'(r >= 0));
        chk("done", 32'(bus.done), 32'(done_m));
        chk("cap_valid", 32'(bus.cap_valid), 32'(cv_m));
        chk("cap_idx", 32'(bus.cap_idx), 32'(idx_m));
        chk("cap_reg", bus.cap_reg, creg_m);
        chk("cap_mem", bus.cap_mem, cmem_m);
        chk("signature", bus.signature, sig_m);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Launch a run; optionally re-pulse start n cycles after launch; time done and count pulses
    task automatic run_timed(input int repulse_at);
        int pulses, done_at;
        int rw_cnt[8], mw_cnt[8];
        for (int i = 0; i < 8; i++) begin rw_cnt[i] = 0; mw_cnt[i] = 0; end
        pulses = 0; done_at = -1;
        bus.start = 1'b1;
        tick();
        for (int n = 1; n <= 70 && done_at < 0; n++) begin
            bus.start = (n == repulse_at);
            tick();
            if (bus.RegWrite === 1'b1) rw_cnt[bus.instruction_A]++;
            if (bus.MemWrite === 1'b1) mw_cnt[bus.instruction_A]++;
            if (bus.cap_valid === 1'b1) begin
                chk("cap_idx_seq", 32'(bus.cap_idx), 32'(pulses));
                pulses++;
            end
            if (bus.done === 1'b1) done_at = n;
        end
        bus.start = 1'b0;
        chk("done_latency", 32'(done_at), 32'd51);
        chk("cap_pulses", 32'(pulses), 32'(NS));
        chk("rw_step1", 32'(rw_cnt[1]), 32'd8);
        chk("rw_step3", 32'(rw_cnt[3]), 32'd8);
        chk("rw_step4", 32'(rw_cnt[4]), 32'd8);
        chk("mw_step2", 32'(mw_cnt[2]), 32'd8);
        chk("rw_step0", 32'(rw_cnt[0] + rw_cnt[2] + mw_cnt[0] + mw_cnt[1]), 32'd0);
        tick();
        tick();
    endtask

    initial begin
        reset = 1'b1; bus.start = 1'b0;
        reg_base = '0; mem_base = '0; inc_en = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (20) tick();

        reg_base = 32'h1000_0000; mem_base = 32'hA000_0000;
        run_timed(0);

        reg_base = $urandom; mem_base = $urandom;
        run_timed(25);

        // reset while step 3 is executing
        reg_base = $urandom; mem_base = $urandom;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (34) tick();
        reset = 1'b1;
        tick();
        chk("rst_addr", 32'(bus.instruction_A), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        repeat (3) tick();
        run_timed(0);

        // random start noise while busy must be ignored
        reg_base = $urandom; mem_base = $urandom;
        bus.start = 1'b1;
        tick();
        for (int n = 1; n <= 60; n++) begin
            bus.start = (n >= 2 && n <= 48) ? 1'($urandom % 2) : 1'b0;
            tick();
        end
        bus.start = 1'b0;
        repeat (3) tick();

        inc_en = 1'b0; reg_base = 32'd1; mem_base = 32'd1;
        run_timed(0);
`ifdef PC_SEQ_SIGNATURE_EN
        chk("sig_equal_probes", bus.signature, 32'h0);
`endif
        reg_base = 32'd1; mem_base = 32'd0;
        run_timed(0);
`ifdef PC_SEQ_SIGNATURE_EN
        chk("sig_reg_only", bus.signature, 32'h0000_001F);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
